rc4_decrypt_ctrl: RTL and testbench

Sequencer for the single-key RC4 decryption datapath. It owns the single-port 256x8 S working RAM, the 32x8 encrypted-message ROM and the 32x8 decrypted-message RAM. On `start` it runs S-array initialisation, key scheduling (KSA) and keystream generation/XOR (PRGA) for one 24-bit key, writing plaintext to the decrypted-message RAM. It reports whether every plaintext byte is a lower-case letter or space, and sits under the key-search top level, which iterates keys.

---
 rtl/rc4_decrypt_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_rc4_decrypt_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_decrypt_ctrl.sv
// RC4 single-key decryption sequencer: S-array init, KSA, then PRGA/XOR into the
// decrypted-message RAM, flagging whether every plaintext byte is a-z or space.
module rc4_decrypt_ctrl #(
    parameter int unsigned MSG_LEN     = 32,
    parameter bit          EARLY_ABORT = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [23:0] key,
    output logic        busy,
    output logic        done,
    output logic        key_valid,
    output logic [7:0]  s_addr,
    output logic [7:0]  s_wdata,
    output logic        s_wren,
    input  logic [7:0]  s_q,
    output logic [4:0]  rom_addr,
    input  logic [7:0]  rom_q,
    output logic [4:0]  dmsg_addr,
    output logic [7:0]  dmsg_wdata,
    output logic        dmsg_wren
);

    localparam int unsigned KW     = 5;
    localparam logic [KW-1:0] K_LAST = KW'(MSG_LEN - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_INIT,
        S_K_RDI, S_K_RDJ, S_K_WRI, S_K_WRJ,
        S_P_RDI, S_P_RDJ, S_P_WRI, S_P_WRJ, S_P_RDF, S_P_WR,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
    logic [KW-1:0] k_q, k_d;
    logic [1:0]    ksel_q, ksel_d;
    logic [23:0]   key_q, key_d;
    logic          busy_q, busy_d, done_q, done_d, key_valid_q, key_valid_d;
    logic [7:0]    key_byte, plain;
    logic          plain_ok;

    // State and datapath registers; synchronous reset returns to IDLE with all cleared.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            i_q         <= 8'd0;
            j_q         <= 8'd0;
            si_q        <= 8'd0;
            sj_q        <= 8'd0;
            k_q         <= '0;
            ksel_q      <= 2'd0;
            key_q       <= 24'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            si_q        <= si_d;
            sj_q        <= sj_d;
            k_q         <= k_d;
            ksel_q      <= ksel_d;
            key_q       <= key_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            key_valid_q <= key_valid_d;
        end
    end

    // Next-state, register updates and memory port drive for each phase.
    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        si_d        = si_q;
        sj_d        = sj_q;
        k_d         = k_q;
        ksel_d      = ksel_q;
        key_d       = key_q;
        key_valid_d = key_valid_q;
        s_addr      = 8'd0;
        s_wdata     = 8'd0;
        s_wren      = 1'b0;
        rom_addr    = '0;
        dmsg_addr   = '0;
        dmsg_wdata  = 8'd0;
        dmsg_wren   = 1'b0;

        // ksel tracks i mod 3 through the KSA without a divider
        case (ksel_q)
            2'd0:    key_byte = key_q[23:16];
            2'd1:    key_byte = key_q[15:8];
            default: key_byte = key_q[7:0];
        endcase
        plain    = s_q ^ rom_q;
        plain_ok = (plain == 8'h20) || ((plain >= 8'h61) && (plain <= 8'h7a));

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_INIT;
                    i_d         = 8'd0;
                    key_d       = key;
                    key_valid_d = 1'b1;
                end
            end
            S_INIT: begin
                s_addr  = i_q;
                s_wdata = i_q;
                s_wren  = 1'b1;
                i_d     = i_q + 8'd1;
                if (i_q == 8'hff) begin
                    state_d = S_K_RDI;
                    j_d     = 8'd0;
                    ksel_d  = 2'd0;
                end
            end
            S_K_RDI: begin
                s_addr  = i_q;
                state_d = S_K_RDJ;
            end
            S_K_RDJ: begin
                si_d    = s_q;
                j_d     = j_q + s_q + key_byte;
                s_addr  = j_d;
                state_d = S_K_WRI;
            end
            S_K_WRI: begin
                s_addr  = i_q;
                s_wdata = s_q;
                s_wren  = 1'b1;
                state_d = S_K_WRJ;
            end
            S_K_WRJ: begin
                s_addr  = j_q;
                s_wdata = si_q;
                s_wren  = 1'b1;
                i_d     = i_q + 8'd1;
                ksel_d  = (ksel_q == 2'd2) ? 2'd0 : ksel_q + 2'd1;
                if (i_q == 8'hff) begin
                    state_d = S_P_RDI;
                    j_d     = 8'd0;
                    k_d     = '0;
                end else begin
                    state_d = S_K_RDI;
                end
            end
            S_P_RDI: begin
                i_d     = i_q + 8'd1;
                s_addr  = i_d;
                state_d = S_P_RDJ;
            end
            S_P_RDJ: begin
                si_d    = s_q;
                j_d     = j_q + s_q;
                s_addr  = j_d;
                state_d = S_P_WRI;
            end
            S_P_WRI: begin
                sj_d    = s_q;
                s_addr  = i_q;
                s_wdata = s_q;
                s_wren  = 1'b1;
                state_d = S_P_WRJ;
            end
            S_P_WRJ: begin
                s_addr  = j_q;
                s_wdata = si_q;
                s_wren  = 1'b1;
                state_d = S_P_RDF;
            end
            S_P_RDF: begin
                s_addr   = si_q + sj_q;
                rom_addr = k_q;
                state_d  = S_P_WR;
            end
            S_P_WR: begin
                rom_addr   = k_q;
                dmsg_addr  = k_q;
                dmsg_wdata = plain;
                dmsg_wren  = 1'b1;
                if (!plain_ok) begin
                    key_valid_d = 1'b0;
                end
                if (!plain_ok && EARLY_ABORT) begin
                    state_d = S_DONE;
                end else if (k_q == K_LAST) begin
                    state_d = S_DONE;
                end else begin
                    k_d     = k_q + KW'(1);
                    state_d = S_P_RDI;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d = (state_d == S_DONE);
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign key_valid = key_valid_q;

endmodule

// File: tb/tb_rc4_decrypt_ctrl.sv
// Bench for rc4_decrypt_ctrl: two instances (EARLY_ABORT=1 and 0) share stimulus,
// each with its own synchronous S RAM and dmsg RAM, checked against a plain RC4 model.
module tb_rc4_decrypt_ctrl;

    localparam int MSG = 32;

    logic        clock = 1'b0;
    logic        reset, start, dmsg_clr;
    logic [23:0] key;

    logic [1:0]      busy_v, done_v, kv_v, s_wren_v, dmsg_wren_v;
    logic [1:0][7:0] s_addr_v, s_wdata_v, s_q_v, rom_q_v, dmsg_wdata_v;
    logic [1:0][4:0] rom_addr_v, dmsg_addr_v;

    logic [7:0] s_mem    [2][256];
    logic [7:0] dmsg_mem [2][MSG];
    logic [7:0] rom_image[MSG];
    logic [7:0] plain_buf[MSG];

    logic [7:0] m_s  [256];
    logic [7:0] m_ks [MSG];
    logic [7:0] m_pt [MSG];

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic [23:0] key;
        int          pulse_at;
        int          reset_at;
        int          exp_n;
        bit          exp_kv;
    } vec_t;

    vec_t vecs[6];

    always #5 clock = ~clock;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        rc4_decrypt_ctrl #(.MSG_LEN(MSG), .EARLY_ABORT(g == 0)) u_dut (
            .clock      (clock),
            .reset      (reset),
            .start      (start),
            .key        (key),
            .busy       (busy_v[g]),
            .done       (done_v[g]),
            .key_valid  (kv_v[g]),
            .s_addr     (s_addr_v[g]),
            .s_wdata    (s_wdata_v[g]),
            .s_wren     (s_wren_v[g]),
            .s_q        (s_q_v[g]),
            .rom_addr   (rom_addr_v[g]),
            .rom_q      (rom_q_v[g]),
            .dmsg_addr  (dmsg_addr_v[g]),
            .dmsg_wdata (dmsg_wdata_v[g]),
            .dmsg_wren  (dmsg_wren_v[g])
        );
    end

    // Synchronous memories: q reflects last cycle's address, read-before-write.
    always @(posedge clock) begin
        for (int u = 0; u < 2; u++) begin
            if (s_wren_v[u]) s_mem[u][s_addr_v[u]] <= s_wdata_v[u];
            s_q_v[u]   <= s_mem[u][s_addr_v[u]];
            rom_q_v[u] <= rom_image[rom_addr_v[u]];
            if (dmsg_clr) begin
                for (int x = 0; x < MSG; x++) dmsg_mem[u][x] <= 8'hee;
            end else if (dmsg_wren_v[u]) begin
                dmsg_mem[u][dmsg_addr_v[u]] <= dmsg_wdata_v[u];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic bit is_text(input logic [7:0] b);
        return (b == 8'h20) || (b >= 8'h61 && b <= 8'h7a);
    endfunction

    // Textbook RC4 over int arithmetic; decrypts rom_image for nbytes bytes.
    task automatic model_run(input logic [23:0] k, input int nbytes);
        int ii, jj, t;
        int kb[3];
        kb[0] = int'(k[23:16]);
        kb[1] = int'(k[15:8]);
        kb[2] = int'(k[7:0]);
        for (int x = 0; x < 256; x++) m_s[x] = 8'(x);
        jj = 0;
        for (int x = 0; x < 256; x++) begin
            jj = (jj + int'(m_s[x]) + kb[x % 3]) % 256;
            t = int'(m_s[x]); m_s[x] = m_s[jj]; m_s[jj] = 8'(t);
        end
        ii = 0; jj = 0;
        for (int n = 0; n < nbytes; n++) begin
            ii = (ii + 1) % 256;
            jj = (jj + int'(m_s[ii])) % 256;
            t = int'(m_s[ii]); m_s[ii] = m_s[jj]; m_s[jj] = 8'(t);
            m_ks[n] = m_s[(int'(m_s[ii]) + int'(m_s[jj])) % 256];
            m_pt[n] = rom_image[n] ^ m_ks[n];
        end
    endtask

    task automatic model_first_bad(input logic [23:0] k, output int n_ea, output bit kv);
        model_run(k, MSG);
        n_ea = MSG;
        kv = 1'b1;
        for (int n = 0; n < MSG; n++) begin
            if (!is_text(m_pt[n]) && kv) begin
                n_ea = n + 1;
                kv = 1'b0;
            end
        end
    endtask

    task automatic encrypt_rom(input logic [23:0] k);
        for (int n = 0; n < MSG; n++) rom_image[n] = 8'h00;
        model_run(k, MSG);
        for (int n = 0; n < MSG; n++) rom_image[n] = m_ks[n] ^ plain_buf[n];
    endtask

    task automatic check_idle(input string name);
        for (int u = 0; u < 2; u++)
            chk(name, 64'({busy_v[u], done_v[u], kv_v[u], s_wren_v[u], dmsg_wren_v[u],
                           s_addr_v[u], s_wdata_v[u], rom_addr_v[u], dmsg_addr_v[u],
                           dmsg_wdata_v[u]}), 64'd0);
    endtask

    task automatic set_vec(input int idx, input logic [23:0] k, input int pa, input int ra);
        vecs[idx].key      = k;
        vecs[idx].pulse_at = pa;
        vecs[idx].reset_at = ra;
        model_first_bad(k, vecs[idx].exp_n, vecs[idx].exp_kv);
    endtask

    // One start/run; cycle 1 is the first cycle after the accepting edge.
    task automatic run_key(input vec_t v);
        int cyc, ierr, n_u, serr, derr;
        int got[2], dcnt[2], berr[2], exp_done[2];
        logic [8:0] s257;
        exp_done[0] = 1280 + 6 * v.exp_n + 1;
        exp_done[1] = 1280 + 6 * MSG + 1;
        got[0] = -1; got[1] = -1;
        dcnt[0] = 0; dcnt[1] = 0; berr[0] = 0; berr[1] = 0;
        ierr = 0; s257 = 9'h1ff;
        @(negedge clock); dmsg_clr = 1'b1;
        @(negedge clock); dmsg_clr = 1'b0; start = 1'b1; key = v.key;
        @(negedge clock); start = 1'b0; key = 24'($urandom);
        cyc = 1;
        while (cyc <= 2000) begin
            if (cyc <= 256 && !(s_wren_v[0] && s_addr_v[0] == 8'(cyc - 1) &&
                                s_wdata_v[0] == 8'(cyc - 1))) ierr++;
            if (cyc == 257) s257 = {s_wren_v[0], s_addr_v[0]};
            for (int u = 0; u < 2; u++) begin
                if (done_v[u]) begin
                    dcnt[u]++;
                    if (got[u] < 0) got[u] = cyc;
                end
                if (busy_v[u] !== (cyc < exp_done[u])) berr[u]++;
            end
            if (cyc == v.pulse_at) begin start = 1'b1; key = 24'h5a5a5a; end
            if (cyc == v.pulse_at + 1) start = 1'b0;
            if (cyc == v.reset_at) begin
                reset = 1'b1;
                @(negedge clock);
                chk("init_pattern_errs", 64'(ierr), 64'd0);
                chk("busy_profile_errs", 64'(berr[0] + berr[1]), 64'd0);
                check_idle("reset_mid_run");
                reset = 1'b0;
                return;
            end
            if (got[0] >= 0 && got[1] >= 0 && cyc >= got[0] + 2 && cyc >= got[1] + 2) break;
            @(negedge clock);
            cyc++;
        end
        chk("init_pattern_errs", 64'(ierr), 64'd0);
        chk("first_ksa_read", 64'(s257), 64'd0);
        for (int u = 0; u < 2; u++) begin
            n_u = (u == 0) ? v.exp_n : MSG;
            chk($sformatf("done_cycle[%0d] key=%06h", u, v.key), 64'(got[u]), 64'(exp_done[u]));
            chk($sformatf("done_pulses[%0d]", u), 64'(dcnt[u]), 64'd1);
            chk($sformatf("busy_profile_errs[%0d]", u), 64'(berr[u]), 64'd0);
            chk($sformatf("key_valid[%0d] key=%06h", u, v.key), 64'(kv_v[u]), 64'(v.exp_kv));
            model_run(v.key, n_u);
            serr = 0; derr = 0;
            for (int x = 0; x < 256; x++) if (s_mem[u][x] !== m_s[x]) serr++;
            for (int x = 0; x < MSG; x++) begin
                if (x < n_u) begin
                    if (dmsg_mem[u][x] !== m_pt[x]) derr++;
                end else if (dmsg_mem[u][x] !== 8'hee) begin
                    derr++;
                end
            end
            chk($sformatf("final_s_errs[%0d]", u), 64'(serr), 64'd0);
            chk($sformatf("dmsg_errs[%0d]", u), 64'(derr), 64'd0);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        string pt_str;
        vec_t  rv;
        logic [23:0] rk;
        int    ch;

        reset = 1'b1; start = 1'b0; key = 24'd0; dmsg_clr = 1'b0;
        repeat (3) @(negedge clock);
        check_idle("reset_state");
        start = 1'b1; key = 24'h000001;
        @(negedge clock);
        start = 1'b0; reset = 1'b0;
        @(negedge clock);
        check_idle("reset_over_start");

        pt_str = "attack at dawn";
        for (int n = 0; n < MSG; n++) plain_buf[n] = (n < pt_str.len()) ? pt_str[n] : 8'h20;
        encrypt_rom(24'h000001);

        set_vec(0, 24'h000000, -1, -1);
        set_vec(1, 24'h000001, -1, -1);
        set_vec(2, 24'h000002, -1, -1);
        set_vec(3, 24'h000001, 500, -1);
        set_vec(4, 24'h000001, -1, 800);
        set_vec(5, 24'h000001, -1, -1);

        for (int t = 0; t < 6; t++) run_key(vecs[t]);

        for (int r = 0; r < 3; r++) begin
            for (int n = 0; n < MSG; n++) begin
                ch = int'($urandom_range(0, 26));
                plain_buf[n] = (ch == 26) ? 8'h20 : 8'(8'h61 + ch);
            end
            rk = 24'($urandom);
            encrypt_rom(rk);
            rv.key = rk; rv.pulse_at = -1; rv.reset_at = -1;
            model_first_bad(rk, rv.exp_n, rv.exp_kv);
            run_key(rv);
            rv.key = 24'($urandom);
            model_first_bad(rv.key, rv.exp_n, rv.exp_kv);
            run_key(rv);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
